// File: rtl/sw_link_delay.sv
// -----------------------------------------------------------------------------
// sw_link_delay
// Inter-PE delay line for the Smith-Waterman systolic array. Sits between the
// last PE of one pass and the first PE of the next and delays one record per
// cycle {valid, s, t, max, v, f} by a run-time selectable number of cycles.
//
// The delay is latched from cfg_depth when a sequence starts (IDLE -> BUSY).
// cfg_depth = 0 is treated as 1 and values above MAX_DEPTH are clamped.
// When the input stream stops, the block drains for depth_q cycles, writing
// zero records. That flush leaves every storage entry in use at zero, so a
// later sequence at a different depth never sees stale valid records.
// A global stall freezes all state, storage and outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   cfg_depth  requested delay, sampled only on sequence start
//   stall      1 = freeze the whole block this cycle
//   valid_in, s_in, t_in, max_in, v_in, f_in   input record
//   valid_out, s_out, t_out, max_out, v_out, f_out   delayed record (registered)
//   busy       state != IDLE
//   done       one-cycle pulse (per advance) at the end of a drain
//   depth_q    latched effective depth
//   occ        number of valid records held (only with SW_LINK_OCC_EN)
//
// Optional feature macro: SW_LINK_OCC_EN (adds the occ output and its counter).
// -----------------------------------------------------------------------------
module sw_link_delay #(
    parameter int BASE_W    = 2,
    parameter int SCORE_W   = 12,
    parameter int MAX_DEPTH = 256,
    parameter int DEPTH_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic               stall,
    input  logic               valid_in,
    input  logic [BASE_W-1:0]  s_in,
    input  logic [BASE_W-1:0]  t_in,
    input  logic [SCORE_W-1:0] max_in,
    input  logic [SCORE_W-1:0] v_in,
    input  logic [SCORE_W-1:0] f_in,
    output logic               valid_out,
    output logic [BASE_W-1:0]  s_out,
    output logic [BASE_W-1:0]  t_out,
    output logic [SCORE_W-1:0] max_out,
    output logic [SCORE_W-1:0] v_out,
    output logic [SCORE_W-1:0] f_out,
    output logic               busy,
    output logic               done,
`ifdef SW_LINK_OCC_EN
    output logic [DEPTH_W:0]   occ,
`endif
    output logic [DEPTH_W-1:0] depth_q
);

    localparam int REC_W  = 1 + 2*BASE_W + 3*SCORE_W;
    // The output register supplies one stage of delay, so the ring only needs
    // depth-1 entries; depth 1 bypasses the ring entirely.
    localparam int RING_N = MAX_DEPTH - 1;
    localparam int PTR_W  = (RING_N > 1) ? $clog2(RING_N) : 1;

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [DEPTH_W-1:0] depth_reg, depth_next;
    logic [DEPTH_W-1:0] eff_depth, depth_use;
    logic [DEPTH_W-1:0] cnt_reg, cnt_next;
    logic               done_reg, done_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next, ring_last;
    logic [REC_W-1:0]   wr_rec, ring_rd, out_reg, out_next;
    logic [REC_W-1:0]   ring_mem [RING_N];
    logic               adv, start, ring_we;

    assign adv   = ~stall;
    assign start = (state_reg == IDLE) && valid_in;

    // Clamp the requested depth into 1..MAX_DEPTH.
    always_comb begin
        eff_depth = cfg_depth;
        if (cfg_depth == '0) begin
            eff_depth = DEPTH_ONE;
        end else if (cfg_depth > DEPTH_MAX) begin
            eff_depth = DEPTH_MAX;
        end
    end

    // On the starting edge the new depth already governs the record written.
    assign depth_use = start ? eff_depth : depth_reg;
    assign ring_last = PTR_W'(depth_use - DEPTH_TWO);

    // Sanitised write data: anything not valid is stored as all zero.
    assign wr_rec   = valid_in ? {1'b1, s_in, t_in, max_in, v_in, f_in} : '0;
    assign ring_rd  = ring_mem[ptr_reg];
    assign ring_we  = adv && (depth_use != DEPTH_ONE);
    // The slot at ptr_reg was written depth-1 advances ago; it moves to the
    // output register on the same edge that the slot is overwritten.
    assign out_next = (depth_use == DEPTH_ONE) ? wr_rec : ring_rd;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (adv) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        depth_next = depth_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_in) begin
                    state_next = BUSY;
                    depth_next = eff_depth;
                end
            end
            BUSY: begin
                if (!valid_in) begin
                    state_next = DRAIN;
                    cnt_next   = DEPTH_ONE;
                end
            end
            DRAIN: begin
                if (valid_in) begin
                    state_next = BUSY;
                    cnt_next   = '0;
                end else if (cnt_reg >= depth_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + DEPTH_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = done_reg;
        depth_q = depth_reg;
        {valid_out, s_out, t_out, max_out, v_out, f_out} = out_reg;
    end

    // Ring pointer restarts at 0 for every sequence so a new depth always
    // begins on a fully flushed region.
    always_comb begin
        if ((state_next == IDLE) || (depth_use == DEPTH_ONE)) begin
            ptr_next = '0;
        end else if (ptr_reg == ring_last) begin
            ptr_next = '0;
        end else begin
            ptr_next = ptr_reg + PTR_ONE;
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_reg <= DEPTH_ONE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            ptr_reg   <= '0;
            out_reg   <= '0;
        end else if (adv) begin
            depth_reg <= depth_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            ptr_reg   <= ptr_next;
            out_reg   <= out_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RING_N; i++) begin
                ring_mem[i] <= '0;
            end
        end else if (ring_we) begin
            ring_mem[ptr_reg] <= wr_rec;
        end
    end

`ifdef SW_LINK_OCC_EN
    // Valid records held: accepted ones minus those that have left the output
    // register. A valid output record leaves on every advance edge.
    logic [DEPTH_W:0] occ_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= '0;
        end else if (adv) begin
            case ({valid_in, out_reg[REC_W-1]})
                2'b10:   occ_reg <= occ_reg + (DEPTH_W+1)'(1);
                2'b01:   occ_reg <= occ_reg - (DEPTH_W+1)'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign occ = occ_reg;
`endif

endmodule

// File: tb/tb_sw_link_delay.sv
// -----------------------------------------------------------------------------
// tb_sw_link_delay
// Directed bench for sw_link_delay. Each scenario drives a fixed stimulus and
// compares outputs cycle by cycle against hand-derived expected values.
// Record payload is a fixed function of the record number (rec_data), so the
// expected data for any delivered record is known without a model.
// -----------------------------------------------------------------------------
module tb_sw_link_delay;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  cfg_depth;
    logic        stall;
    logic        valid_in;
    logic [1:0]  s_in, t_in;
    logic [11:0] max_in, v_in, f_in;
    logic        valid_out;
    logic [1:0]  s_out, t_out;
    logic [11:0] max_out, v_out, f_out;
    logic        busy, done;
    logic [8:0]  depth_q;
`ifdef SW_LINK_OCC_EN
    logic [9:0]  occ;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int k;

    always #5 clk = ~clk;

    sw_link_delay dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_depth (cfg_depth),
        .stall     (stall),
        .valid_in  (valid_in),
        .s_in      (s_in),
        .t_in      (t_in),
        .max_in    (max_in),
        .v_in      (v_in),
        .f_in      (f_in),
        .valid_out (valid_out),
        .s_out     (s_out),
        .t_out     (t_out),
        .max_out   (max_out),
        .v_out     (v_out),
        .f_out     (f_out),
        .busy      (busy),
        .done      (done),
`ifdef SW_LINK_OCC_EN
        .occ       (occ),
`endif
        .depth_q   (depth_q)
    );

    // Payload {s, t, max, v, f} derived from record number v.
    function automatic logic [39:0] rec_data(input int v);
        logic [11:0] vv;
        vv = 12'(v);
        return {vv[1:0], vv[3:2], 12'(vv * 12'd3), vv, vv ^ 12'h5A5};
    endfunction

    function automatic logic [39:0] dut_data();
        return {s_out, t_out, max_out, v_out, f_out};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int kk, input bit exp_valid, input int exp_v);
        check($sformatf("%s_valid@%0d", tag, kk), valid_out, exp_valid);
        check($sformatf("%s_data@%0d", tag, kk), dut_data(),
              exp_valid ? rec_data(exp_v) : 40'd0);
        if (valid_out)
            $display("rx %s cyc=%0d v=%0d", tag, kk, v_out);
    endtask

    task automatic drive_rec(input int v);
        valid_in = 1'b1;
        {s_in, t_in, max_in, v_in, f_in} = rec_data(v);
    endtask

    // Non-valid cycles carry junk that must never reach the outputs.
    task automatic drive_none();
        valid_in = 1'b0;
        s_in = 2'b11; t_in = 2'b11;
        max_in = 12'hFFF; v_in = 12'hFFF; f_in = 12'hFFF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        cfg_depth = 9'd129;
        drive_none();

        // ---- reset state
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out("RST", c, 1'b0, 0);
            check("RST_busy", busy, 1'b0);
            check("RST_done", done, 1'b0);
            check("RST_depth", depth_q, 9'd1);
`ifdef SW_LINK_OCC_EN
            check("RST_occ", occ, 10'd0);
`endif
        end
        rst = 1'b0;

        // ---- A: depth 129, 128 records v=1..128
        cfg_depth = 9'd129;
        for (int c = 0; c <= 260; c++) begin
            if (c < 128) drive_rec(c + 1); else drive_none();
            tick();
            k = c + 1;
            check_out("A", k, (k >= 129 && k <= 256), k - 128);
            check($sformatf("A_done@%0d", k), done, (k == 258));
            check($sformatf("A_busy@%0d", k), busy, (k >= 1 && k <= 257));
            if (k == 1) check("A_depth", depth_q, 9'd129);
        end

        // ---- B: depth 4 with stalls (cycles 2-4 and 8), records 10,11,12
        cfg_depth = 9'd4;
        for (int c = 0; c <= 13; c++) begin
            stall = (c >= 2 && c <= 4) || (c == 8);
            if (stall) drive_rec(99);
            else if (c == 0) drive_rec(10);
            else if (c == 1) drive_rec(11);
            else if (c == 5) drive_rec(12);
            else drive_none();
            tick();
            k = c + 1;
            check_out("B", k, (k >= 7 && k <= 10),
                      (k == 7) ? 10 : ((k == 10) ? 12 : 11));
            check($sformatf("B_done@%0d", k), done, (k == 12));
            check($sformatf("B_busy@%0d", k), busy, (k >= 1 && k <= 11));
            if (k == 1) check("B_depth", depth_q, 9'd4);
`ifdef SW_LINK_OCC_EN
            if (k == 7) check("B_occ7", occ, 10'd3);
            if (k == 9) check("B_occ9", occ, 10'd2);
`endif
        end
        stall = 1'b0;

        // ---- C1: cfg_depth 0 -> depth 1; cfg change mid-BUSY is ignored
        cfg_depth = 9'd0;
        for (int c = 0; c <= 6; c++) begin
            if (c <= 2) drive_rec(5 + c); else drive_none();
            if (c == 2) cfg_depth = 9'd8;
            tick();
            k = c + 1;
            check_out("C1", k, (k >= 1 && k <= 3), k + 4);
            check($sformatf("C1_done@%0d", k), done, (k == 5));
            check($sformatf("C1_busy@%0d", k), busy, (k >= 1 && k <= 4));
            if (k == 1 || k == 3) check($sformatf("C1_depth@%0d", k), depth_q, 9'd1);
        end

        // ---- C2: cfg_depth 300 clamps to 256
        cfg_depth = 9'd300;
        for (int c = 0; c <= 259; c++) begin
            if (c == 0) drive_rec(9); else drive_none();
            tick();
            k = c + 1;
            check_out("C2", k, (k == 256), 9);
            check($sformatf("C2_done@%0d", k), done, (k == 258));
            check($sformatf("C2_busy@%0d", k), busy, (k >= 1 && k <= 257));
            if (k == 1) check("C2_depth", depth_q, 9'd256);
        end

        // ---- D: depth 16 sequence then immediately depth 3
        cfg_depth = 9'd16;
        for (int c = 0; c <= 36; c++) begin
            if (c < 20) drive_rec(100 + c); else drive_none();
            tick();
            k = c + 1;
            check_out("D16", k, (k >= 16 && k <= 35), 100 + k - 16);
            check($sformatf("D16_done@%0d", k), done, (k == 37));
        end
        cfg_depth = 9'd3;
        for (int c = 0; c <= 9; c++) begin
            if (c < 4) drive_rec(200 + c); else drive_none();
            tick();
            k = c + 1;
            check_out("D3", k, (k >= 3 && k <= 6), 200 + k - 3);
            check($sformatf("D3_done@%0d", k), done, (k == 8));
            check($sformatf("D3_busy@%0d", k), busy, (k >= 1 && k <= 7));
            if (k == 1) check("D3_depth", depth_q, 9'd3);
        end

        // ---- E: depth 5, restart 2 cycles into drain
        cfg_depth = 9'd5;
        for (int c = 0; c <= 16; c++) begin
            if (c <= 3) drive_rec(300 + c);
            else if (c >= 6 && c <= 8) drive_rec(304 + c - 6);
            else drive_none();
            tick();
            k = c + 1;
            check_out("E", k, (k >= 5 && k <= 8) || (k >= 11 && k <= 13),
                      (k <= 8) ? 300 + k - 5 : 304 + k - 11);
            check($sformatf("E_done@%0d", k), done, (k == 15));
            check($sformatf("E_busy@%0d", k), busy, (k >= 1 && k <= 14));
        end

        // ---- F: async reset mid-BUSY at depth 64 with 30 records in flight
        cfg_depth = 9'd64;
        for (int c = 0; c <= 29; c++) begin
            drive_rec(400 + c);
            tick();
        end
        check("F_busy_pre", busy, 1'b1);
`ifdef SW_LINK_OCC_EN
        check("F_occ_pre", occ, 10'd30);
`endif
        drive_rec(430);
        #3;
        rst = 1'b1;
        #1;
        check_out("F_rst", 0, 1'b0, 0);
        check("F_rst_busy", busy, 1'b0);
        check("F_rst_done", done, 1'b0);
        check("F_rst_depth", depth_q, 9'd1);
`ifdef SW_LINK_OCC_EN
        check("F_rst_occ", occ, 10'd0);
`endif
        drive_none();
        tick();
        tick();
        check("F_rst_done2", done, 1'b0);
        rst = 1'b0;

        // New depth-64 sequence: any surviving old record would show up here.
        for (int c = 0; c <= 70; c++) begin
            if (c == 0) drive_rec(500); else drive_none();
            tick();
            k = c + 1;
            check_out("F2", k, (k == 64), 500);
            check($sformatf("F2_done@%0d", k), done, (k == 66));
            check($sformatf("F2_busy@%0d", k), busy, (k >= 1 && k <= 65));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
